// File: rtl/divisor_secuencial.sv
// Sequential restoring divider, one quotient bit per cycle, signed (DIV) and unsigned (DIVU).
// Signed operands are reduced to magnitudes on accept; signs are reapplied in a single FIX cycle.
module divisor_secuencial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic [CW-1:0]    cnt;

    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             take;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // shifted partial remainder carries one extra bit so the compare never overflows
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign take    = rem_sh >= {2'b00, dvs};
    assign rem_sub = rem_sh[WIDTH:0] - {1'b0, dvs};
    assign a_abs   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_abs   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            rem   <= '0;
                            quo   <= a_abs;
                            dvs   <= b_abs;
                            cnt   <= '0;
                            neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r <= is_signed && dividend[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    rem <= take ? rem_sub : rem_sh[WIDTH:0];
                    quo <= {quo[WIDTH-2:0], take};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    state       <= DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    quotient    <= neg_q ? -quo : quo;
                    remainder   <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/divisor_secuencial.md
DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request pulse; operands sampled on the same edge.
REQ-005 is_signed  input  1  1 = two's-complement division (DIV), 0 = unsigned (DIVU).
REQ-006 dividend  input  WIDTH  numerator.
REQ-007 divisor  input  WIDTH  denominator.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle pulse; results valid from this cycle.
REQ-010 quotient  output  WIDTH  result quotient, held until next accepted start.
REQ-011 remainder  output  WIDTH  result remainder, held until next accepted start.
REQ-012 div_by_zero  output  1  flag for the last completed operation, held with the results.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, FIX and DONE; the reset state SHALL be IDLE.
REQ-014 In IDLE or DONE, start=1 SHALL be accepted: operands and is_signed are latched, divisor==0 goes to DONE, otherwise to RUN.
REQ-015 start SHALL be ignored while busy=1, with no effect on operands, state or outputs.
REQ-016 The signed mode SHALL latch the absolute values of both operands and record the quotient sign (sign(dividend) XOR sign(divisor)) and the remainder sign (sign(dividend)).
REQ-017 RUN SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH cycles, using a WIDTH+1-bit partial remainder.
REQ-018 Each step: shift {rem,quo} left by 1; if rem >= divisor then rem -= divisor and quo LSB = 1, else quo LSB = 0.
REQ-019 After WIDTH steps the FSM SHALL enter FIX for one cycle: signed mode negates the quotient and/or remainder per REQ-016; unsigned mode passes them through unchanged.
REQ-020 FIX SHALL transition to DONE; DONE SHALL last one cycle with done=1 and then return to IDLE unless a new start is accepted in that cycle.
REQ-021 Latency: the accept edge is cycle 0; done=1 SHALL occur in cycle WIDTH+2 (34 for WIDTH=32); busy SHALL be high in cycles 1..WIDTH+1.
REQ-022 Divide by zero: done=1 in cycle 1, busy never asserted, quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-023 div_by_zero SHALL be 0 for every completed non-zero-divisor operation.
REQ-024 The signed overflow case -2^(WIDTH-1) / -1 SHALL return quotient = 0x80000000 and remainder = 0 with no flag (natural wrap of the negation).
REQ-025 Results SHALL satisfy dividend == quotient*divisor + remainder (mod 2^WIDTH); the quotient truncates toward zero; a non-zero remainder takes the sign of the dividend (signed) or is < divisor (unsigned).
REQ-026 quotient, remainder and div_by_zero SHALL change only in the DONE cycle and are stable otherwise.

Reset
REQ-027 rst_n=0 at any rising edge SHALL force IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 on that edge.
REQ-028 A reset asserted mid-operation SHALL abort the division with no done pulse; the first start after release SHALL be accepted normally.
REQ-029 start SHALL be ignored in any cycle where rst_n=0.

Verification
REQ-030 Unsigned: start, is_signed=0, dividend=100, divisor=7 -> done at cycle 34, quotient=14, remainder=2, div_by_zero=0.
REQ-031 Signed: dividend=-7 (0xFFFFFFF9), divisor=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); dividend=7, divisor=-2 -> quotient=-3, remainder=1.
REQ-032 Zero divisor: dividend=0x12345678, divisor=0 -> done at cycle 1, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, busy stays 0.
REQ-033 Overflow and unsigned edge: signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-034 Handshake: a second start with different operands at cycle 10 is ignored and the first result is unchanged; back-to-back start in the DONE cycle is accepted and its done occurs 34 cycles later.
REQ-035 Reset mid-op: rst_n=0 at cycle 15 -> outputs zero, no done pulse; a new start of 9/3 after release -> quotient=3, remainder=0.
